// File: rtl/osc_voice_mixer.sv
// osc_voice_mixer
//   Mixes the time-multiplexed sine samples from the oscillator stage.
//   Each slot carries one (voice, oscillator) sample. The mixer scales the
//   sample by that oscillator's level register and sums the V_OSC oscillators
//   of a voice. Once per complete voice frame it emits one saturated 17-bit
//   sample, tagged with the voice index. Slot-sequence errors are flagged.
//
// Ports
//   sCLK_XVXENVS  clock; all logic on the rising edge
//   iRST          synchronous active-high reset
//   sample_in     signed 17-bit oscillator sample
//   sample_valid  sample_in / vx_in / ox_in valid this cycle
//   vx_in, ox_in  voice / oscillator index of the sample
//   data, adr     register write data / address
//   write         write strobe (one cycle per write)
//   osc_sel       oscillator register bank select
//   voice_free    per-voice idle flags; an idle voice outputs 0
//   voice_out     signed mixed voice sample
//   voice_idx     voice index of voice_out
//   out_valid     one-cycle pulse when voice_out is new
//   seq_err       sticky slot-sequence error flag
module osc_voice_mixer #(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 4,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2
) (
  input  logic                      sCLK_XVXENVS,
  input  logic                      iRST,
  input  logic signed [16:0]        sample_in,
  input  logic                      sample_valid,
  input  logic [V_WIDTH-1:0]        vx_in,
  input  logic [O_WIDTH-1:0]        ox_in,
  input  logic [7:0]                data,
  input  logic [6:0]                adr,
  input  logic                      write,
  input  logic                      osc_sel,
  input  logic [VOICES-1:0]         voice_free,
  output logic signed [16:0]        voice_out,
  output logic [V_WIDTH-1:0]        voice_idx,
  output logic                      out_valid,
  output logic                      seq_err
);

  localparam int ACC_W = 21;
  localparam logic signed [ACC_W-1:0] SAT_MAX = 21'sd65535;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -21'sd65536;
  localparam logic [O_WIDTH-1:0] LAST_OX = O_WIDTH'(V_OSC - 1);

  // ---------------------------------------------------------------------------
  // Level registers: oscillator o lives at address 7 + 16*o.
  // ---------------------------------------------------------------------------
  logic [7:0]       o_level [V_OSC];
  logic [V_OSC-1:0] level_hit;

  genvar gi;
  generate
    for (gi = 0; gi < V_OSC; gi++) begin : g_level_dec
      localparam logic [6:0] LEVEL_ADR = 7'(7 + gi * 16);
      assign level_hit[gi] = write && osc_sel && (adr == LEVEL_ADR);
    end
  endgenerate

  always_ff @(posedge sCLK_XVXENVS) begin
    for (int o = 0; o < V_OSC; o++) begin
      if (iRST) begin
        o_level[o] <= 8'd128;
      end else if (level_hit[o]) begin
        o_level[o] <= data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: scale. The level is treated as unsigned (0..255), so it is given
  // a zero sign bit before the signed multiply. The >>>7 makes 128 unity gain.
  // ---------------------------------------------------------------------------
  logic signed [25:0] prod;
  logic signed [18:0] scaled;

  assign prod   = sample_in * $signed({1'b0, o_level[ox_in]});
  assign scaled = 19'(prod >>> 7);

  logic                     s1_valid_reg;
  logic signed [18:0]       s1_scaled_reg;
  logic [V_WIDTH-1:0]       s1_vx_reg;
  logic [O_WIDTH-1:0]       s1_ox_reg;

  // ---------------------------------------------------------------------------
  // Stage 2: frame accumulation and sequence checking
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  logic [O_WIDTH-1:0]       exp_ox_reg, exp_ox_next;
  logic [V_WIDTH-1:0]       frame_vx_reg, frame_vx_next;
  logic                     frame_ok_reg, frame_ok_next;
  logic                     seq_err_next;
  logic                     frame_end;
  logic signed [ACC_W-1:0]  scaled_ext;
  logic signed [16:0]       sat_val;

  assign scaled_ext = {{(ACC_W-19){s1_scaled_reg[18]}}, s1_scaled_reg};

  always_comb begin
    acc_next      = acc_reg;
    exp_ox_next   = exp_ox_reg;
    frame_vx_next = frame_vx_reg;
    frame_ok_next = frame_ok_reg;
    seq_err_next  = seq_err;
    frame_end     = 1'b0;

    if (s1_valid_reg) begin
      exp_ox_next = (s1_ox_reg == LAST_OX) ? '0 : s1_ox_reg + 1'b1;
      frame_end   = (s1_ox_reg == LAST_OX);

      if (s1_ox_reg == '0) begin
        // Oscillator 0 always opens a new frame; a non-zero expected index
        // means the previous frame never completed.
        acc_next      = scaled_ext;
        frame_vx_next = s1_vx_reg;
        frame_ok_next = 1'b1;
        if (exp_ox_reg != '0) begin
          seq_err_next = 1'b1;
        end
      end else if (s1_ox_reg == exp_ox_reg && s1_vx_reg == frame_vx_reg) begin
        acc_next = acc_reg + scaled_ext;
      end else begin
        seq_err_next  = 1'b1;
        frame_ok_next = 1'b0;
      end
    end
  end

  always_comb begin
    if (acc_next > SAT_MAX) begin
      sat_val = 17'sd65535;
    end else if (acc_next < SAT_MIN) begin
      sat_val = -17'sd65536;
    end else begin
      sat_val = acc_next[16:0];
    end
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    if (iRST) begin
      s1_valid_reg  <= 1'b0;
      s1_scaled_reg <= '0;
      s1_vx_reg     <= '0;
      s1_ox_reg     <= '0;
      acc_reg       <= '0;
      exp_ox_reg    <= '0;
      frame_vx_reg  <= '0;
      frame_ok_reg  <= 1'b0;
      seq_err       <= 1'b0;
      out_valid     <= 1'b0;
      voice_out     <= '0;
      voice_idx     <= '0;
    end else begin
      s1_valid_reg  <= sample_valid;
      if (sample_valid) begin
        s1_scaled_reg <= scaled;
        s1_vx_reg     <= vx_in;
        s1_ox_reg     <= ox_in;
      end
      acc_reg      <= acc_next;
      exp_ox_reg   <= exp_ox_next;
      frame_vx_reg <= frame_vx_next;
      frame_ok_reg <= frame_ok_next;
      seq_err      <= seq_err_next;
      out_valid    <= frame_end && frame_ok_next;
      // Outputs only move on a valid frame; otherwise they hold.
      if (frame_end && frame_ok_next) begin
        voice_idx <= frame_vx_next;
        voice_out <= voice_free[frame_vx_next] ? '0 : sat_val;
      end
    end
  end

endmodule

// File: tb/tb_osc_voice_mixer.sv
module tb_osc_voice_mixer;

  localparam int VOICES = 8;

  logic               clk;
  logic               rst;
  logic signed [16:0] sample_in;
  logic               sample_valid;
  logic [2:0]         vx_in;
  logic [1:0]         ox_in;
  logic [7:0]         data;
  logic [6:0]         adr;
  logic               write;
  logic               osc_sel;
  logic [VOICES-1:0]  voice_free;
  logic signed [16:0] voice_out;
  logic [2:0]         voice_idx;
  logic               out_valid;
  logic               seq_err;

  osc_voice_mixer dut (
    .sCLK_XVXENVS(clk),
    .iRST(rst),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .vx_in(vx_in),
    .ox_in(ox_in),
    .data(data),
    .adr(adr),
    .write(write),
    .osc_sel(osc_sel),
    .voice_free(voice_free),
    .voice_out(voice_out),
    .voice_idx(voice_idx),
    .out_valid(out_valid),
    .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- reference model (plain integer arithmetic) -------------
  typedef struct {
    int vx;
    int val;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   m_level[4];
  int   m_exp, m_fvx, m_acc;
  bit   m_fok, m_err;

  function automatic int sat17(int v);
    if (v > 65535)  return 65535;
    if (v < -65536) return -65536;
    return v;
  endfunction

  function automatic void model_reset();
    for (int o = 0; o < 4; o++) m_level[o] = 128;
    m_exp = 0; m_fvx = 0; m_acc = 0; m_fok = 0; m_err = 0;
  endfunction

  function automatic void model_sample(int vx, int ox, int s, int c);
    int scaled_v;
    scaled_v = (s * m_level[ox]) >>> 7;
    if (ox == 0) begin
      if (m_exp != 0) m_err = 1;
      m_acc = scaled_v; m_fvx = vx; m_fok = 1;
    end else if (ox == m_exp && vx == m_fvx) begin
      m_acc = m_acc + scaled_v;
    end else begin
      m_err = 1; m_fok = 0;
    end
    m_exp = (ox + 1) % 4;
    if (ox == 3 && m_fok) begin
      exp_t e;
      e.vx  = m_fvx;
      e.val = voice_free[m_fvx] ? 0 : sat17(m_acc);
      e.cyc = c + 2;
      sb.push_back(e);
    end
  endfunction

  // ---------------- stimulus helpers ----------------------------------------
  task automatic send(input int vx, input int ox, input int s);
    int sv;
    sv = s;
    sample_valid = 1'b1;
    vx_in        = 3'(vx);
    ox_in        = 2'(ox);
    sample_in    = sv[16:0];
    model_sample(vx, ox, s, cyc);
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input int a, input int d, input bit sel);
    write = 1'b1; osc_sel = sel; adr = 7'(a); data = 8'(d);
    if (sel) begin
      for (int o = 0; o < 4; o++) if (a == 7 + 16 * o) m_level[o] = d;
    end
    @(posedge clk); #1;
    write = 1'b0; osc_sel = 1'b0;
  endtask

  task automatic frame(input int vx, input int s0, input int s1, input int s2, input int s3);
    send(vx, 0, s0); send(vx, 1, s1); send(vx, 2, s2); send(vx, 3, s3);
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 131071)) - 65536;
  endfunction

  // ---------------- monitor / scoreboard ------------------------------------
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("out: cyc=%0d voice=%0d value=%0d (want voice=%0d value=%0d)",
                 cyc, voice_idx, voice_out, e.vx, e.val);
        check("voice_idx", int'(voice_idx), e.vx);
        check("voice_out", int'(voice_out), e.val);
        check("latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence -------------------------------------------
  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0; vx_in = '0; ox_in = '0;
    data = '0; adr = '0; write = 1'b0; osc_sel = 1'b0; voice_free = '0;
    model_reset();
    idle(3);
    rst = 1'b0;
    idle(1);
    check("reset_voice_out", int'(voice_out), 0);
    check("reset_voice_idx", int'(voice_idx), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_seq_err",   int'(seq_err), 0);

    // Default unity levels
    frame(2, 1000, 2000, -500, 100);
    idle(4);
    check("seq_err_clean", int'(seq_err), int'(m_err));

    // Level writes, including ignored ones, then arithmetic-shift check
    wr(7, 64, 1'b1);
    wr(23, 0, 1'b1);
    wr(8, 7, 1'b1);      // non-matching address
    wr(39, 3, 1'b0);     // bank not selected
    frame(0, 4000, 4000, 0, 0);
    frame(0, -3, 0, 0, 0);
    frame(3, 1000, 1000, 1000, 1000);
    idle(4);

    // Saturation
    for (int o = 0; o < 4; o++) wr(7 + 16 * o, 255, 1'b1);
    frame(6, 65535, 65535, 65535, 65535);
    frame(7, -65536, -65536, -65536, -65536);
    idle(4);

    // Idle voice forced to zero
    voice_free = 8'b0010_0000;
    frame(5, 1234, -4321, 999, 5);
    idle(4);
    voice_free = '0;

    // Sequence error 0,1,3 then a clean frame
    send(1, 0, 100); send(1, 1, 200); send(1, 3, 300);
    idle(4);
    check("seq_err_after_skip", int'(seq_err), 1);
    check("seq_err_model", int'(seq_err), int'(m_err));
    frame(1, 111, 222, 333, 444);
    idle(4);
    check("seq_err_sticky", int'(seq_err), 1);

    // Back-to-back all voices with reset in the middle of voice 4
    for (int o = 0; o < 4; o++) wr(7 + 16 * o, int'($urandom_range(0, 255)), 1'b1);
    for (int v = 0; v < 4; v++)
      frame(v, rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample());
    send(4, 0, rnd_sample());
    send(4, 1, rnd_sample());
    idle(4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    model_reset();
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_seq_err",   int'(seq_err), 0);
    check("midrst_voice_out", int'(voice_out), 0);
    send(4, 2, rnd_sample());
    send(4, 3, rnd_sample());
    for (int v = 5; v < 8; v++)
      frame(v, rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample());
    idle(4);
    check("seq_err_after_rst_tail", int'(seq_err), int'(m_err));

    // Levels are back to unity after reset
    frame(3, 1000, 2000, 3000, 4000);
    idle(4);

    // Random frames with gaps, random levels and idle voices
    for (int f = 0; f < 20; f++) begin
      int vx;
      if ($urandom_range(0, 2) == 0)
        wr(7 + 16 * int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b1);
      voice_free = 8'($urandom_range(0, 255));
      vx = int'($urandom_range(0, 7));
      for (int o = 0; o < 4; o++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        send(vx, o, rnd_sample());
      end
      idle(3);
    end
    idle(4);
    check("final_seq_err", int'(seq_err), int'(m_err));
    check("pending_outputs", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
